// File: rtl/mul_pkg.sv
// mul_pkg: funct3 encodings, FSM states and operand decode shared by the iterative multiplier
package mul_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_FINISH} state_t;
  // {rs1 signed, rs2 signed}; unknown encodings fall back to MUL (both signed)
  function automatic logic [1:0] op_signed(input logic [2:0] f3);
    return {f3 != F3_MULHU, !(f3 == F3_MULHSU || f3 == F3_MULHU)};
  endfunction
  // high half of the product is returned for MULH, MULHSU and MULHU only
  function automatic logic op_high(input logic [2:0] f3);
    return f3 == F3_MULH || f3 == F3_MULHSU || f3 == F3_MULHU;
  endfunction
endpackage

// File: rtl/mul_partial.sv
// mul_partial: unsigned multiplicand times one BPC-bit multiplier digit
module mul_partial #(
  parameter int XLEN = 32,
  parameter int BPC  = 4
) (
  input  logic [XLEN-1:0]     i_mcand,
  input  logic [BPC-1:0]      i_digit,
  output logic [XLEN+BPC-1:0] o_pp
);
  assign o_pp = (XLEN+BPC)'(i_mcand) * (XLEN+BPC)'(i_digit);
endmodule

// File: rtl/mul_iterative.sv
// mul_iterative: sign/magnitude shift-add multiplier for MUL/MULH/MULHSU/MULHU retiring BPC bits per cycle
module mul_iterative
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int BPC   = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [2:0]       funct3,
  input  logic [TAG_W-1:0] tag_in,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);
  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);
  localparam int AW = 2 * XLEN;
  if (!(XLEN == 32 || XLEN == 64) || (XLEN % BPC) != 0) begin : g_bad_params
    $error("mul_iterative: XLEN must be 32 or 64 and BPC must divide XLEN");
  end
  state_t           r_state, w_next;
  logic [XLEN-1:0]  r_mcand, r_mplier, r_result;
  logic [2:0]       r_f3;
  logic [TAG_W-1:0] r_tag, r_tag_out;
  logic             r_neg;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       w_sgn;
  logic [XLEN-1:0]  w_mag1, w_mag2, w_res;
  logic [XLEN+BPC-1:0] w_pp;
  logic [CW-1:0]    w_idx;
  logic [AW-1:0]    w_prod;
  logic             w_accept, w_finish;
  assign w_sgn    = op_signed(r_f3);
  assign w_mag1   = (w_sgn[1] && r_mcand[XLEN-1]) ? -r_mcand : r_mcand;
  assign w_mag2   = (w_sgn[0] && r_mplier[XLEN-1]) ? -r_mplier : r_mplier;
  assign w_idx    = CW'(N) - r_cnt;
  assign w_prod   = r_neg ? -r_acc : r_acc;
  assign w_res    = op_high(r_f3) ? w_prod[AW-1:XLEN] : w_prod[XLEN-1:0];
  assign w_accept = r_state == S_IDLE && start && !flush;
  assign w_finish = r_state == S_FINISH && !flush;
  assign busy     = r_state != S_IDLE;
  assign done     = w_finish;
  assign result   = w_finish ? w_res : r_result;
  assign tag_out  = w_finish ? r_tag : r_tag_out;
  mul_partial #(.XLEN(XLEN), .BPC(BPC)) u_partial (
    .i_mcand(r_mcand),
    .i_digit(r_mplier[BPC-1:0]),
    .o_pp   (w_pp)
  );
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next state: flush wins everywhere; COMPUTE leaves after the last digit
  always_comb begin
    w_next = flush ? S_IDLE
           : r_state == S_IDLE    ? (start ? S_LOAD : S_IDLE)
           : r_state == S_LOAD    ? S_COMPUTE
           : r_state == S_COMPUTE ? (r_cnt == CW'(1) ? S_FINISH : S_COMPUTE)
           : S_IDLE;
  end
  // datapath: capture, convert to magnitudes, accumulate digits, publish on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_f3      <= '0;
      r_tag     <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_tag_out <= '0;
    end else begin
      if (w_accept) begin
        r_mcand  <= rs1;
        r_mplier <= rs2;
        r_f3     <= funct3;
        r_tag    <= tag_in;
      end
      if (r_state == S_LOAD) begin
        r_mcand  <= w_mag1;
        r_mplier <= w_mag2;
        r_neg    <= (w_sgn[1] & r_mcand[XLEN-1]) ^ (w_sgn[0] & r_mplier[XLEN-1]);
        r_acc    <= '0;
        r_cnt    <= CW'(N);
      end
      if (r_state == S_COMPUTE) begin
        r_acc    <= r_acc + (AW'(w_pp) << (BPC * w_idx));
        r_mplier <= r_mplier >> BPC;
        r_cnt    <= r_cnt - CW'(1);
      end
      if (w_finish) begin
        r_result  <= w_res;
        r_tag_out <= r_tag;
      end
    end
  end
endmodule

// File: tb/tb_mul_iterative.sv
// tb_mul_iterative: directed checks of the default multiplier plus a BPC/XLEN sweep against a wide reference product
module tb_mul_iterative;
  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [31:0] rs1, rs2, result;
  logic [2:0]  funct3;
  logic [4:0]  tag_in, tag_out;
  logic        busy, done;
  int          checks = 0;
  int          errors = 0;
  logic        sw_start [4];
  logic [63:0] sw_rs1 [4];
  logic [63:0] sw_rs2 [4];
  logic [2:0]  sw_f3 [4];
  logic [4:0]  sw_tag [4];
  logic        sw_busy [4];
  logic        sw_done [4];
  logic [31:0] sw_r32 [3];
  logic [63:0] sw_r64;
  logic [4:0]  sw_tout [4];
  always #5 clk = ~clk;
  mul_iterative dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .tag_in(tag_in), .busy(busy), .done(done), .result(result), .tag_out(tag_out)
  );
  for (genvar g = 0; g < 3; g++) begin : g_sw
    mul_iterative #(.XLEN(32), .BPC(g == 0 ? 1 : g == 1 ? 2 : 8), .TAG_W(5)) u_sw (
      .clk(clk), .reset(reset), .start(sw_start[g]), .flush(flush),
      .rs1(sw_rs1[g][31:0]), .rs2(sw_rs2[g][31:0]), .funct3(sw_f3[g]), .tag_in(sw_tag[g]),
      .busy(sw_busy[g]), .done(sw_done[g]), .result(sw_r32[g]), .tag_out(sw_tout[g])
    );
  end
  mul_iterative #(.XLEN(64), .BPC(4), .TAG_W(5)) u_sw64 (
    .clk(clk), .reset(reset), .start(sw_start[3]), .flush(flush),
    .rs1(sw_rs1[3]), .rs2(sw_rs2[3]), .funct3(sw_f3[3]), .tag_in(sw_tag[3]),
    .busy(sw_busy[3]), .done(sw_done[3]), .result(sw_r64), .tag_out(sw_tout[3])
  );
  function automatic logic [63:0] ref_mul(input int xl, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] m, ea, eb, p;
    logic sa, sb, hi;
    sa = f != 3'd3;
    sb = f != 3'd2 && f != 3'd3;
    hi = f == 3'd1 || f == 3'd2 || f == 3'd3;
    m  = (xl == 64) ? {64'b0, {64{1'b1}}} : {96'b0, 32'hFFFF_FFFF};
    ea = {64'b0, a} & m;
    eb = {64'b0, b} & m;
    if (sa && a[xl-1]) ea = ea | ~m;
    if (sb && b[xl-1]) eb = eb | ~m;
    p = ea * eb;
    if (xl == 64) return hi ? p[127:64] : p[63:0];
    return hi ? {32'b0, p[63:32]} : {32'b0, p[31:0]};
  endfunction
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; tag_in = t; start = 1'b1;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin lat = c; break; end
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; start = 1'b1; flush = 1'b0; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; tag_in = 5'd7;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, result, tag_out} !== 39'd0) begin
      errors++; $display("FAIL reset_outputs: busy=%b done=%b result=%h tag=%h, required all zero", busy, done, result, tag_out);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
  endtask
  task automatic test_mul;
    int lat;
    issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'h15);
    wait_done(lat);
    checks++;
    if (lat != 10) begin errors++; $display("FAIL mul_latency: got %0d required 10", lat); end
    checks++;
    if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h required ffffffeb", result); end
    checks++;
    if (tag_out !== 5'h15) begin errors++; $display("FAIL mul_tag: got %h required 15", tag_out); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'hFFFF_FFEB || tag_out !== 5'h15) begin
      errors++; $display("FAIL mul_after_done: done=%b busy=%b result=%h tag=%h required 0 0 ffffffeb 15", done, busy, result, tag_out);
    end
  endtask
  task automatic test_corners;
    logic [2:0]  fv [8];
    logic [31:0] av [8];
    logic [31:0] bv [8];
    logic [31:0] ev [8];
    int lat;
    fv = '{3'd1, 3'd3, 3'd2, 3'd3, 3'd0, 3'd7, 3'd2, 3'd1};
    av = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bv = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ev = '{32'h4000_0000, 32'h4000_0000, 32'hC000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      issue(fv[i], av[i], bv[i], 5'(i));
      wait_done(lat);
      checks++;
      if (lat != 10 || result !== ev[i] || tag_out !== 5'(i)) begin
        errors++; $display("FAIL corner_%0d: latency %0d result %h tag %h, required 10 %h %h", i, lat, result, tag_out, ev[i], 5'(i));
      end
    end
  endtask
  task automatic test_busy_ignore;
    int nb, nd;
    logic [31:0] res;
    logic [4:0]  tg;
    nb = 0; nd = 0; res = '0; tg = '0;
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      nb += int'(busy);
      if (done) begin nd++; res = result; tg = tag_out; end
      if (nd == 0) begin
        start = 1'b1; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; tag_in = 5'($urandom);
      end else start = 1'b0;
    end
    checks++;
    if (nb != 10) begin errors++; $display("FAIL busy_cycles: got %0d required 10", nb); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL busy_done_count: got %0d required 1", nd); end
    checks++;
    if (res !== 32'hFFFF_FFFE || tg !== 5'd7) begin
      errors++; $display("FAIL busy_result: got %h tag %h required fffffffe tag 07", res, tg);
    end
  endtask
  task automatic test_flush;
    int lat, nd;
    issue(3'd0, 32'd5, 32'd6, 5'd3);
    wait_done(lat);
    checks++;
    if (lat != 10 || result !== 32'd30) begin errors++; $display("FAIL flush_prior: latency %0d result %h required 10 0000001e", lat, result); end
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      rs1 = 32'd0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_compute_busy: busy=%b done=%b required 0 0", busy, done); end
    nd = 0;
    for (int k = 0; k < 12; k++) begin @(negedge clk); nd += int'(done); end
    checks++;
    if (nd != 0 || result !== 32'd30 || tag_out !== 5'd3) begin
      errors++; $display("FAIL flush_compute_retain: dones %0d result %h tag %h required 0 0000001e 03", nd, result, tag_out);
    end
    issue(3'd0, 32'h1234_5678, 32'h0000_0010, 5'd12);
    wait_done(lat);
    checks++;
    if (lat != 10 || result !== 32'h2345_6780 || tag_out !== 5'd12) begin
      errors++; $display("FAIL flush_restart: latency %0d result %h tag %h required 10 23456780 0c", lat, result, tag_out);
    end
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4);
    for (int k = 1; k <= 10; k++) begin @(negedge clk); start = 1'b0; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL flush_finish_reach: done=%b required 1", done); end
    flush = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || result !== 32'h2345_6780 || tag_out !== 5'd12) begin
      errors++; $display("FAIL flush_finish_gate: done=%b result %h tag %h required 0 23456780 0c", done, result, tag_out);
    end
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== 32'h2345_6780) begin errors++; $display("FAIL flush_finish_after: busy=%b result %h required 0 23456780", busy, result); end
    issue(3'd0, 32'd2, 32'd2, 5'd1);
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_over_start: busy=%b required 0", busy); end
    issue(3'd0, 32'd2, 32'd2, 5'd1);
    repeat (4) begin @(negedge clk); start = 1'b0; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== 32'd0 || tag_out !== 5'd0) begin
      errors++; $display("FAIL reset_mid_op: busy=%b result %h tag %h required 0 0 0", busy, result, tag_out);
    end
  endtask
  task automatic test_back_to_back;
    int nd;
    int dc [2];
    nd = 0; dc = '{0, 0};
    issue(3'd0, 32'd3, 32'd4, 5'd1);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (done) begin
        if (nd < 2) dc[nd] = i;
        nd++;
        checks++;
        if (result !== 32'd12) begin errors++; $display("FAIL b2b_result: got %h required 0000000c", result); end
      end
    end
    start = 1'b0;
    checks++;
    if (nd != 2 || dc[0] != 10 || dc[1] != 21) begin
      errors++; $display("FAIL b2b_spacing: dones %0d at %0d,%0d required 2 at 10,21", nd, dc[0], dc[1]);
    end
  endtask
  task automatic test_sweep(input int k);
    int xl, bp, lat;
    logic [63:0] msk, a, b, res, exp_r;
    xl = (k == 3) ? 64 : 32;
    bp = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 4;
    msk = (xl == 64) ? {64{1'b1}} : 64'hFFFF_FFFF;
    for (int op = 0; op < 4; op++) begin
      for (int v = 0; v < 4; v++) begin
        a = (v == 0) ? (64'd1 << (xl - 1)) : (v == 1) ? msk : {$urandom, $urandom} & msk;
        b = (v == 0) ? (64'd1 << (xl - 1)) : (v == 1) ? msk : {$urandom, $urandom} & msk;
        exp_r = ref_mul(xl, 3'(op), a, b);
        @(negedge clk);
        sw_rs1[k] = a; sw_rs2[k] = b; sw_f3[k] = 3'(op); sw_tag[k] = 5'(op * 4 + v); sw_start[k] = 1'b1;
        lat = 0; res = '0;
        for (int c = 1; c <= 100; c++) begin
          @(negedge clk);
          sw_start[k] = 1'b0;
          if (sw_done[k]) begin
            lat = c;
            res = (k == 3) ? sw_r64 : {32'b0, sw_r32[(k < 3) ? k : 0]};
            break;
          end
        end
        checks++;
        if (lat != xl / bp + 2) begin errors++; $display("FAIL sweep_latency x%0d_b%0d op%0d: got %0d required %0d", xl, bp, op, lat, xl / bp + 2); end
        checks++;
        if (res !== exp_r || sw_tout[k] !== 5'(op * 4 + v)) begin
          errors++; $display("FAIL sweep_result x%0d_b%0d op%0d a=%h b=%h: got %h tag %h required %h tag %h", xl, bp, op, a, b, res, sw_tout[k], exp_r, 5'(op * 4 + v));
        end
      end
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 4; k++) begin
      sw_start[k] = 1'b0; sw_rs1[k] = '0; sw_rs2[k] = '0; sw_f3[k] = '0; sw_tag[k] = '0;
    end
    test_reset;
    test_mul;
    test_corners;
    test_busy_ignore;
    test_flush;
    test_back_to_back;
    for (int k = 0; k < 4; k++) test_sweep(k);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
